// File: rtl/bayer_crop_demosaic.sv
`default_nettype none
// =====================================================================
// Module   : bayer_crop_demosaic
// Brief    : Captures raw Bayer lines from an asynchronous camera bus,
//            2x2-bins row pairs into RGB, crops to a window and streams
//            the pixels with linear framebuffer addresses.
// Revision : 1.0 - initial release
// =====================================================================
module bayer_crop_demosaic #(
    parameter int PIX_W    = 10,
    parameter int LINE_W   = 1288,
    parameter int X_OFFSET = 224,
    parameter int Y_OFFSET = 59,
    parameter int X_SIZE   = 400,
    parameter int Y_SIZE   = 400,
    parameter int ADDR_W   = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pixel_clk,
    input  logic [PIX_W-1:0]   pixel_data,
    input  logic               lv,
    input  logic               fv,
    input  logic [1:0]         bayer_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*PIX_W-1:0] rgb,
    output logic [7:0]         rgb8,
    output logic [ADDR_W-1:0]  address,
    output logic               frame_done,
    output logic [1:0]         status
);

    localparam int BANK_D    = LINE_W / 2;
    localparam int I_W       = (BANK_D > 1) ? $clog2(BANK_D) : 1;
    localparam int COL_W     = $clog2(LINE_W + 1);
    localparam int ROW_MAX_I = 2 * (Y_OFFSET + Y_SIZE) + 1;
    localparam int ROW_W     = $clog2(ROW_MAX_I + 1);

    localparam logic [I_W-1:0]    I_FIRST   = I_W'(X_OFFSET);
    localparam logic [I_W-1:0]    I_LAST    = I_W'(X_OFFSET + X_SIZE - 1);
    localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(LINE_W);
    localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(2 * Y_OFFSET + 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(2 * (Y_OFFSET + Y_SIZE) - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROW_MAX_I);
    localparam logic [ADDR_W-1:0] ADDR_ROW  = ADDR_W'(X_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Synchronisers; fv chain resets high so a frame already in progress
    // at reset release is never mistaken for a fresh fv rise.
    logic [1:0]       pclk_sync_q, lv_sync_q, fv_sync_q;
    logic [PIX_W-1:0] pix_s1_q, pix_s2_q;
    logic             pclk_prev_q, lv_prev_q, fv_prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pclk_sync_q <= 2'b00;
            lv_sync_q   <= 2'b00;
            fv_sync_q   <= 2'b11;
            pix_s1_q    <= '0;
            pix_s2_q    <= '0;
            pclk_prev_q <= 1'b0;
            lv_prev_q   <= 1'b0;
            fv_prev_q   <= 1'b1;
        end else begin
            pclk_sync_q <= {pclk_sync_q[0], pixel_clk};
            lv_sync_q   <= {lv_sync_q[0], lv};
            fv_sync_q   <= {fv_sync_q[0], fv};
            pix_s1_q    <= pixel_data;
            pix_s2_q    <= pix_s1_q;
            pclk_prev_q <= pclk_sync_q[1];
            lv_prev_q   <= lv_sync_q[1];
            fv_prev_q   <= fv_sync_q[1];
        end
    end

    logic pclk_rise, lv_fall, fv_rise, fv_s;

    assign pclk_rise = pclk_sync_q[1] & ~pclk_prev_q;
    assign lv_fall   = lv_prev_q & ~lv_sync_q[1];
    assign fv_rise   = fv_sync_q[1] & ~fv_prev_q;
    assign fv_s      = fv_sync_q[1];

    // Frame / capture state
    logic               active_q, active_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         status_q, status_d;

    // Emit state
    logic [I_W-1:0]     i_q, i_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               last_row_q, last_row_d;
    logic               out_valid_q, out_valid_d;
    logic [3*PIX_W-1:0] rgb_q, rgb_d;
    logic [7:0]         rgb8_q, rgb8_d;
    logic               frame_done_q, frame_done_d;

    logic capture, to_a, wr_en, rd_en, overrun;

    assign capture = active_q & fv_s & pclk_rise & lv_sync_q[1];
    assign to_a    = ~row_q[0];
    assign wr_en   = capture & (col_q < COL_LIM);
    assign rd_en   = (state_q == S_RD);
    assign overrun = capture & to_a & (state_q != S_IDLE);

    // Each line buffer is split into even/odd column banks so one RD
    // cycle fetches both pixels of a bin with a single port per bank.
    logic [PIX_W-1:0] mem_ae [BANK_D];
    logic [PIX_W-1:0] mem_ao [BANK_D];
    logic [PIX_W-1:0] mem_be [BANK_D];
    logic [PIX_W-1:0] mem_bo [BANK_D];
    logic [PIX_W-1:0] a0_q, a1_q, b0_q, b1_q;
    logic [I_W-1:0]   wr_idx;

    assign wr_idx = col_q[I_W:1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case ({to_a, col_q[0]})
                2'b10:   mem_ae[wr_idx] <= pix_s2_q;
                2'b11:   mem_ao[wr_idx] <= pix_s2_q;
                2'b00:   mem_be[wr_idx] <= pix_s2_q;
                default: mem_bo[wr_idx] <= pix_s2_q;
            endcase
        end
        if (rd_en) begin
            a0_q <= mem_ae[i_q];
            a1_q <= mem_ao[i_q];
            b0_q <= mem_be[i_q];
            b1_q <= mem_bo[i_q];
        end
    end

    // Bayer phase -> channel mapping; green sum kept one bit wider
    logic [PIX_W-1:0] r_bin, g_bin, b_bin;
    logic [PIX_W:0]   g_sum;

    always_comb begin
        r_bin = a0_q;
        b_bin = b1_q;
        g_sum = {1'b0, a1_q} + {1'b0, b0_q};
        case (sel_q)
            2'd0: begin
                r_bin = a0_q;
                b_bin = b1_q;
                g_sum = {1'b0, a1_q} + {1'b0, b0_q};
            end
            2'd1: begin
                r_bin = a1_q;
                b_bin = b0_q;
                g_sum = {1'b0, a0_q} + {1'b0, b1_q};
            end
            2'd2: begin
                r_bin = b0_q;
                b_bin = a1_q;
                g_sum = {1'b0, a0_q} + {1'b0, b1_q};
            end
            default: begin
                r_bin = b1_q;
                b_bin = a0_q;
                g_sum = {1'b0, a1_q} + {1'b0, b0_q};
            end
        endcase
        g_bin = g_sum[PIX_W:1];
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        row_d        = row_q;
        col_d        = col_q;
        sel_d        = sel_q;
        status_d     = status_q;
        i_d          = i_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        last_row_d   = last_row_q;
        out_valid_d  = out_valid_q;
        rgb_d        = rgb_q;
        rgb8_d       = rgb8_q;
        frame_done_d = 1'b0;

        if (capture) begin
            if (col_q < COL_LIM) begin
                col_d = col_q + 1'b1;
            end else begin
                status_d[1] = 1'b1;
            end
            if (to_a && (state_q != S_IDLE)) begin
                status_d[0] = 1'b1;
            end
        end

        if (active_q && lv_fall) begin
            col_d = '0;
            if (row_q != ROW_MAX) begin
                row_d = row_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (active_q && fv_s && lv_fall && row_q[0] &&
                    (row_q >= ROW_FIRST) && (row_q <= ROW_LAST)) begin
                    state_d    = S_RD;
                    i_d        = I_FIRST;
                    row_base_d = addr_q;
                    last_row_d = (row_q == ROW_LAST);
                end
            end
            S_RD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                rgb_d       = {r_bin, g_bin, b_bin};
                rgb8_d      = {r_bin[PIX_W-1 -: 3], g_bin[PIX_W-1 -: 3], b_bin[PIX_W-1 -: 2]};
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + 1'b1;
                    i_d         = i_q + 1'b1;
                    if (i_q == I_LAST) begin
                        state_d      = S_IDLE;
                        frame_done_d = last_row_q;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
        endcase

        // An abort cancels any same-cycle accept and re-aligns to the next row
        if (overrun) begin
            state_d      = S_IDLE;
            out_valid_d  = 1'b0;
            addr_d       = row_base_q + ADDR_ROW;
            frame_done_d = 1'b0;
        end

        if (!fv_s) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            active_d    = 1'b0;
        end

        if (fv_rise) begin
            state_d     = S_IDLE;
            active_d    = 1'b1;
            row_d       = '0;
            col_d       = '0;
            addr_d      = '0;
            status_d    = '0;
            sel_d       = bayer_sel;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            active_q     <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            sel_q        <= '0;
            status_q     <= '0;
            i_q          <= '0;
            addr_q       <= '0;
            row_base_q   <= '0;
            last_row_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            rgb_q        <= '0;
            rgb8_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            row_q        <= row_d;
            col_q        <= col_d;
            sel_q        <= sel_d;
            status_q     <= status_d;
            i_q          <= i_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            last_row_q   <= last_row_d;
            out_valid_q  <= out_valid_d;
            rgb_q        <= rgb_d;
            rgb8_q       <= rgb8_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign rgb        = rgb_q;
    assign rgb8       = rgb8_q;
    assign address    = addr_q;
    assign frame_done = frame_done_q;
    assign status     = status_q;

endmodule

`default_nettype wire
